pipeline_mem_responder: RTL

Memory-side responder for the pipelined CPU's shared memory bus (MemData/ReadMemEN/WriteMemEN/MemoryAdr).
- Serves instruction fetches from an instruction bank (MemoryAdr[31]=0) and data accesses from a data bank (MemoryAdr[31]=1).
- Reads are answered combinationally in the same cycle, as the CPU requires.
- Data writes are posted into a small write buffer. The buffer drains into the single-port data bank on cycles with no data read. Reads are forwarded from the buffer.

---
 rtl/pipeline_mem_pkg.sv | 13 +
 rtl/mem_write_buffer.sv | 76 +++++++
 rtl/pipeline_mem_responder.sv | 104 ++++++++++
 3 files changed

// File: rtl/pipeline_mem_pkg.sv
// Shared types and constants for the pipelined CPU memory responder.
package pipeline_mem_pkg;

    localparam int          REGION_BIT = 31;
    localparam logic [31:0] FAULT_DATA = 32'h0;

    typedef struct packed {
        logic        valid;
        logic [29:0] index;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/mem_write_buffer.sv
// Posted-write FIFO for the data bank with newest-match read forwarding.
module mem_write_buffer
    import pipeline_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [29:0]              push_index,
    input  logic [31:0]              push_data,
    input  logic                     pop,
    output logic [29:0]              head_index,
    output logic [31:0]              head_data,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [29:0]              lookup_index,
    output logic                     hit,
    output logic [31:0]              hit_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         entries [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              pop_ok;
    logic [PW-1:0]     slot;

    assign pop_ok     = pop && (count != '0);
    assign head_index = entries[head].index;
    assign head_data  = entries[head].data;

    // Pop is applied before push so a full-buffer write reuses the freed head slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (pop_ok) begin
                entries[head].valid <= 1'b0;
                head                <= head + PW'(1);
            end
            if (push) begin
                entries[tail] <= '{valid: 1'b1, index: push_index, data: push_data};
                tail          <= tail + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    // Walk from oldest to newest so the last match found is the newest write.
    always_comb begin
        hit      = 1'b0;
        hit_data = FAULT_DATA;
        slot     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PW'(k);
            if (entries[slot].valid && (entries[slot].index == lookup_index)) begin
                hit      = 1'b1;
                hit_data = entries[slot].data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count <= CW'(DEPTH));
        end
    end

endmodule

// File: rtl/pipeline_mem_responder.sv
// Memory-side responder: instruction bank, data bank with posted-write buffer,
// combinational reads on the shared tri-state bus and a sticky fault flag.
module pipeline_mem_responder
    import pipeline_mem_pkg::*;
#(
    parameter int    IMEM_WORDS = 1024,
    parameter int    DMEM_WORDS = 1024,
    parameter int    WB_DEPTH   = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic                      clk,
    input  logic                      reset,
    inout  wire logic [31:0]          MemData,
    input  logic                      ReadMemEN,
    input  logic                      WriteMemEN,
    input  logic [31:0]               MemoryAdr,
    output logic [$clog2(WB_DEPTH):0] WBCount,
    output logic                      MemFault
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    logic [28:0] word_index;
    logic [31:0] index_ext;
    logic        data_bank;
    logic        imem_in_range;
    logic        dmem_in_range;
    logic        read_active;
    logic        data_read;
    logic        wr_push;
    logic        drain;
    logic        fault_now;
    logic [31:0] read_word;
    logic [29:0] head_index;
    logic [31:0] head_data;
    logic        wb_hit;
    logic [31:0] wb_hit_data;
    logic        addr_unused;

    assign word_index    = MemoryAdr[30:2];
    assign index_ext     = {3'b000, word_index};
    assign data_bank     = MemoryAdr[REGION_BIT];
    assign imem_in_range = index_ext < 32'(IMEM_WORDS);
    assign dmem_in_range = index_ext < 32'(DMEM_WORDS);
    assign addr_unused   = ^{MemoryAdr[1:0], head_index[29:DAW]};

    // A simultaneous write request takes the bus, so it is never a read cycle.
    assign read_active = ReadMemEN && !WriteMemEN;
    assign data_read   = read_active && data_bank;
    assign wr_push     = WriteMemEN && data_bank && dmem_in_range;
    assign drain       = (WBCount != '0) && !data_read;
    assign fault_now   = (read_active && !(data_bank ? dmem_in_range : imem_in_range))
                       || (WriteMemEN && !(data_bank && dmem_in_range));

    mem_write_buffer #(
        .DEPTH(WB_DEPTH)
    ) u_write_buffer (
        .clk          (clk),
        .reset        (reset),
        .push         (wr_push),
        .push_index   ({1'b0, word_index}),
        .push_data    (MemData),
        .pop          (drain),
        .head_index   (head_index),
        .head_data    (head_data),
        .count        (WBCount),
        .lookup_index ({1'b0, word_index}),
        .hit          (wb_hit),
        .hit_data     (wb_hit_data)
    );

    always_comb begin
        read_word = FAULT_DATA;
        if (data_bank) begin
            if (dmem_in_range) begin
                read_word = wb_hit ? wb_hit_data : dmem[word_index[DAW-1:0]];
            end
        end else if (imem_in_range) begin
            read_word = imem[word_index[IAW-1:0]];
        end
    end

    assign MemData = read_active ? read_word : 'z;

    // Bank contents survive reset; only the buffer state is discarded.
    always_ff @(posedge clk) begin
        if (drain) begin
            dmem[head_index[DAW-1:0]] <= head_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MemFault <= 1'b0;
        end else if (fault_now) begin
            MemFault <= 1'b1;
        end
    end

endmodule
